serial_receiver_param: RTL and testbench

//   Parametrised UART-style serial receiver; successor to the fixed 8-bit receiver in the Pong link path.

---
 rtl/serial_receiver_param.sv | 263 ++++++++++++++++++++++++++
 tb/tb_serial_receiver_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver_param.sv
// -----------------------------------------------------------------------------
// serial_receiver_param
//   UART-style serial receiver with a configurable frame format. Bits are
//   timed internally from the system clock (CLKS_PER_BIT clocks per bit) and
//   sampled at mid-bit. The start bit is re-checked at half a bit time, so
//   short low glitches on an idle line are ignored. Each completed frame is
//   offered to a one-entry holding register with a valid/ack handshake.
//
// Parameters
//   CLKS_PER_BIT  system clocks per serial bit (>= 4)
//   DATA_BITS     payload bits per frame, LSB first (5..9)
//   PARITY_MODE   0 = none, 1 = even, 2 = odd
//   STOP_BITS     stop bits checked (1..2)
//
// Ports
//   bounderClock      in   system clock, rising edge
//   reset             in   asynchronous, active-low reset
//   rxbit             in   serial line, idle high, asynchronous
//   in_ack            in   consumer accepts dataout this cycle
//   dataout           out  payload from the holding register
//   OUT_STATUS_READY  out  holding register valid
//   parity_err        out  parity mismatch on the held frame
//   frame_err         out  a stop bit was sampled low on the held frame
//   overrun           out  sticky: a frame was dropped while the holder was full
// -----------------------------------------------------------------------------
module serial_receiver_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 bounderClock,
    input  logic                 reset,
    input  logic                 rxbit,
    input  logic                 in_ack,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 OUT_STATUS_READY,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
    localparam logic          ODD_PARITY = (PARITY_MODE == 2);
    localparam logic          HAS_PARITY = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_LOAD     = 3'd5,
        S_BRK_WAIT = 3'd6
    } state_t;

    // True when payload plus received parity bit disagree with the configured sense.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] payload,
                                        input logic                 sample);
        return ((^payload) ^ sample) != ODD_PARITY;
    endfunction

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic                 fr_bad_q, fr_bad_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 rdy_q, rdy_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 load_s;
    logic                 ack_s;

    // Two-flop synchroniser path for the asynchronous serial line.
    always_comb begin
        sync1_d = rxbit;
        sync2_d = sync1_q;
    end

    assign rx_s = sync2_q;

    // Next-state and bit-timing logic of the frame receiver.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        fr_bad_d  = fr_bad_q;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d   = S_START;
                    par_bad_d = 1'b0;
                    fr_bad_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    // Line order is LSB first, so shifting in at the top
                    // leaves bit 0 in shreg[0] after the last sample.
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    par_bad_d = parity_bad(shreg_q, rx_s);
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        fr_bad_d = 1'b1;
                    end else begin
                        fr_bad_d = fr_bad_q;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_LOAD: begin
                clk_cnt_d = '0;
                // After a framing error the line may still be held low (break);
                // wait for it to go idle so the break yields only one frame.
                state_d   = fr_bad_q ? S_BRK_WAIT : S_IDLE;
            end
            S_BRK_WAIT: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BRK_WAIT;
                end
            end
            default: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign load_s = (state_q == S_LOAD);
    assign ack_s  = in_ack && rdy_q;

    // Holding register, valid/ack handshake and sticky overrun.
    always_comb begin
        dout_d = dout_q;
        rdy_d  = rdy_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (load_s) begin
            // An ack in the LOAD cycle frees the holder for the new frame.
            if (!rdy_q || in_ack) begin
                dout_d = shreg_q;
                perr_d = par_bad_q;
                ferr_d = fr_bad_q;
                rdy_d  = 1'b1;
                ovr_d  = ack_s ? 1'b0 : ovr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ack_s) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
        end
    end

    // Synchroniser and receiver state registers.
    always_ff @(posedge bounderClock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            fr_bad_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            fr_bad_q  <= fr_bad_d;
        end
    end

    // Output holding registers.
    always_ff @(posedge bounderClock or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            rdy_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            rdy_q  <= rdy_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    assign dataout          = dout_q;
    assign OUT_STATUS_READY = rdy_q;
    assign parity_err       = perr_q;
    assign frame_err        = ferr_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_serial_receiver_param.sv
// -----------------------------------------------------------------------------
// tb_serial_receiver_param
//   Directed bench for serial_receiver_param. Four receivers with different
//   frame formats share clock and reset: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 9N2.
//   Expected frames are queued when sent and compared when the receiver
//   presents them.
// -----------------------------------------------------------------------------
module tb_serial_receiver_param;

    localparam int CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx;
    logic [3:0] ack;
    wire  [7:0] d0, d1, d2;
    wire  [8:0] d3;
    wire  [3:0] rdy, perr, ferr, ovr;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_none (
        .bounderClock(clk), .reset(rst_n), .rxbit(rx[0]), .in_ack(ack[0]), .dataout(d0),
        .OUT_STATUS_READY(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

    serial_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
        .bounderClock(clk), .reset(rst_n), .rxbit(rx[1]), .in_ack(ack[1]), .dataout(d1),
        .OUT_STATUS_READY(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

    serial_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
        .bounderClock(clk), .reset(rst_n), .rxbit(rx[2]), .in_ack(ack[2]), .dataout(d2),
        .OUT_STATUS_READY(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

    serial_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(2)) u_wide (
        .bounderClock(clk), .reset(rst_n), .rxbit(rx[3]), .in_ack(ack[3]), .dataout(d3),
        .OUT_STATUS_READY(rdy[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]));

    function automatic logic [8:0] dout_of(input int idx);
        case (idx)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            2:       return {1'b0, d2};
            default: return d3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [8:0] data, input logic pe, input logic fe);
        exp_t e;
        e.data = data;
        e.pe   = pe;
        e.fe   = fe;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input int idx, input logic b);
        rx[idx] = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends one frame on line idx. With ack_at_load, in_ack is high exactly
    // for the receiver's LOAD cycle: the last stop bit is sampled on the 11th
    // rising edge after it is driven (2 sync + half bit), LOAD is the next cycle.
    task automatic send_frame(input int idx, input logic [8:0] data, input logic par_bit,
                              input logic stop_val, input bit ack_at_load);
        int nbits;
        int nstop;
        nbits = (idx == 3) ? 9 : 8;
        nstop = (idx == 3) ? 2 : 1;
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(idx, data[i]);
        if (idx == 1 || idx == 2) drive_bit(idx, par_bit);
        for (int s = 0; s < nstop - 1; s++) drive_bit(idx, stop_val);
        rx[idx] = stop_val;
        if (ack_at_load) begin
            repeat (11) @(negedge clk);
            ack[idx] = 1'b1;
            @(negedge clk);
            ack[idx] = 1'b0;
            repeat (CPB - 12) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Waits (bounded) for the holder to be valid, then checks it against the queue head.
    task automatic wait_check(input int idx, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (rdy[idx] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_ready", tag), 32'(rdy[idx]), 32'h1);
        chk($sformatf("%s_queue", tag), 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_data", tag), 32'(dout_of(idx)), 32'(e.data));
            chk($sformatf("%s_perr", tag), 32'(perr[idx]), 32'(e.pe));
            chk($sformatf("%s_ferr", tag), 32'(ferr[idx]), 32'(e.fe));
        end
    endtask

    task automatic ack_pulse(input int idx);
        ack[idx] = 1'b1;
        @(negedge clk);
        ack[idx] = 1'b0;
    endtask

    task automatic chk_zero(input int idx, input string tag);
        chk($sformatf("%s_dout%0d", tag, idx), 32'(dout_of(idx)), 32'h0);
        chk($sformatf("%s_rdy%0d", tag, idx), 32'(rdy[idx]), 32'h0);
        chk($sformatf("%s_perr%0d", tag, idx), 32'(perr[idx]), 32'h0);
        chk($sformatf("%s_ferr%0d", tag, idx), 32'(ferr[idx]), 32'h0);
        chk($sformatf("%s_ovr%0d", tag, idx), 32'(ovr[idx]), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        rx    = 4'hF;
        ack   = 4'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_zero(i, "reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // T1: plain 8N1 frame, then ack clears valid and keeps data
        push_exp(9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b0);
        wait_check(0, "t1");
        chk("t1_ovr", 32'(ovr[0]), 32'h0);
        ack_pulse(0);
        chk("t1_rdy_after_ack", 32'(rdy[0]), 32'h0);
        chk("t1_dout_kept", 32'(dout_of(0)), 32'h0A5);

        // T2: 6-clock glitch on the idle line
        rx[0] = 1'b0;
        repeat (6) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("t2_rdy", 32'(rdy[0]), 32'h0);
        chk("t2_perr", 32'(perr[0]), 32'h0);
        chk("t2_ferr", 32'(ferr[0]), 32'h0);
        chk("t2_ovr", 32'(ovr[0]), 32'h0);

        // T3: even then odd parity, wrong then right parity bit
        push_exp(9'h007, 1'b1, 1'b0);
        send_frame(1, 9'h007, 1'b0, 1'b1, 1'b0);
        wait_check(1, "t3_even_bad");
        ack_pulse(1);
        push_exp(9'h007, 1'b0, 1'b0);
        send_frame(1, 9'h007, 1'b1, 1'b1, 1'b0);
        wait_check(1, "t3_even_good");
        ack_pulse(1);
        push_exp(9'h007, 1'b1, 1'b0);
        send_frame(2, 9'h007, 1'b1, 1'b1, 1'b0);
        wait_check(2, "t3_odd_bad");
        ack_pulse(2);
        push_exp(9'h007, 1'b0, 1'b0);
        send_frame(2, 9'h007, 1'b0, 1'b1, 1'b0);
        wait_check(2, "t3_odd_good");
        ack_pulse(2);

        // T4: bad stop followed by a 40-bit break
        push_exp(9'h03C, 1'b0, 1'b1);
        send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0);
        wait_check(0, "t4_break");
        ack_pulse(0);
        seen = 0;
        repeat (40 * CPB) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) seen++;
        end
        chk("t4_extra_frames", 32'(seen), 32'h0);
        rx[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("t4_idle_rdy", 32'(rdy[0]), 32'h0);
        push_exp(9'h081, 1'b0, 1'b0);
        send_frame(0, 9'h081, 1'b0, 1'b1, 1'b0);
        wait_check(0, "t4_after");
        ack_pulse(0);

        // T5: overrun, then ack on the LOAD cycle
        push_exp(9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b0);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b0);
        wait_check(0, "t5_held");
        chk("t5_ovr_set", 32'(ovr[0]), 32'h1);
        ack_pulse(0);
        chk("t5_rdy_cleared", 32'(rdy[0]), 32'h0);
        chk("t5_ovr_cleared", 32'(ovr[0]), 32'h0);
        push_exp(9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b0);
        wait_check(0, "t5b_first");
        push_exp(9'h022, 1'b0, 1'b0);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1);
        chk("t5b_ovr", 32'(ovr[0]), 32'h0);
        wait_check(0, "t5b_second");
        send_frame(0, 9'h044, 1'b0, 1'b1, 1'b0);
        chk("t6_pre_ovr", 32'(ovr[0]), 32'h1);
        chk("t6_pre_dout", 32'(dout_of(0)), 32'h022);

        // T6: asynchronous reset during bit 4, then a clean frame
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, ((8'h5A >> i) & 8'h01) != 8'h00);
        rx[0] = 1'b1;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero(0, "t6_async");
        rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("t6_partial_dropped", 32'(rdy[0]), 32'h0);
        push_exp(9'h05A, 1'b0, 1'b0);
        send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b0);
        wait_check(0, "t6_after");
        ack_pulse(0);

        // 9 data bits, 2 stop bits
        push_exp(9'h1FF, 1'b0, 1'b0);
        send_frame(3, 9'h1FF, 1'b0, 1'b1, 1'b0);
        wait_check(3, "wide_1ff");
        ack_pulse(3);
        chk("wide_rdy_after_ack", 32'(rdy[3]), 32'h0);
        push_exp(9'h155, 1'b0, 1'b0);
        send_frame(3, 9'h155, 1'b0, 1'b1, 1'b0);
        wait_check(3, "wide_155");
        ack_pulse(3);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
